// File: rtl/motion_pkg.sv
// Shared encodings, constants and helpers for the line-following motion controller
// and the alu it drives.
package motion_pkg;

    typedef enum logic [2:0] {
        SRC1_ACCUM  = 3'd0,
        SRC1_ITERM  = 3'd1,
        SRC1_ERROR  = 3'd2,
        SRC1_ERRDIV = 3'd3,
        SRC1_FWD    = 3'd4
    } src1sel_e;

    typedef enum logic [2:0] {
        SRC0_A2D    = 3'd0,
        SRC0_INTGRL = 3'd1,
        SRC0_ICOMP  = 3'd2,
        SRC0_PCOMP  = 3'd3,
        SRC0_PTERM  = 3'd4
    } src0sel_e;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SETTLE = 4'd1,
        ST_CONV_R = 4'd2,
        ST_ACC_R  = 4'd3,
        ST_CONV_L = 4'd4,
        ST_ACC_L  = 4'd5,
        ST_INTG   = 4'd6,
        ST_ICMP   = 4'd7,
        ST_PCMP   = 4'd8,
        ST_R1     = 4'd9,
        ST_R2     = 4'd10,
        ST_L1     = 4'd11,
        ST_L2     = 4'd12
    } state_e;

    localparam logic [1:0]  PAIR_IN  = 2'd0;
    localparam logic [1:0]  PAIR_MID = 2'd1;
    localparam logic [1:0]  PAIR_OUT = 2'd2;

    localparam logic [11:0] FWD_STEP = 12'h010;
    localparam logic [11:0] FWD_MAX  = 12'h37F;
    localparam logic [11:0] ITERM    = 12'h500;
    localparam logic [13:0] PTERM    = 14'h3680;

    localparam logic [15:0] SAT_POS  = 16'h07FF;
    localparam logic [15:0] SAT_NEG  = 16'hF800;

    function automatic logic [2:0] chnl_right(input logic [1:0] pair);
        case (pair)
            PAIR_IN:  return 3'd1;
            PAIR_MID: return 3'd4;
            PAIR_OUT: return 3'd3;
            default:  return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] chnl_left(input logic [1:0] pair);
        case (pair)
            PAIR_IN:  return 3'd0;
            PAIR_MID: return 3'd2;
            PAIR_OUT: return 3'd7;
            default:  return 3'd0;
        endcase
    endfunction

    // Emitter enable vector ordered {outer, mid, inner}.
    function automatic logic [2:0] pair_enables(input logic [1:0] pair);
        case (pair)
            PAIR_IN:  return 3'b001;
            PAIR_MID: return 3'b010;
            PAIR_OUT: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] sat12(input logic signed [31:0] v);
        if (v > 32'sd2047) begin
            return SAT_POS;
        end else if (v < -32'sd2048) begin
            return SAT_NEG;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/motion_cntrl_alu.sv
// Shared datapath: add/subtract with x2/x4 scaling, 12-bit saturation, and a
// two-clock fixed-point multiply (product >>> 12, saturated).
module motion_cntrl_alu
    import motion_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] accum_i,
    input  logic [15:0] iterm_i,
    input  logic [15:0] error_i,
    input  logic [15:0] errdiv_i,
    input  logic [15:0] fwd_i,
    input  logic [15:0] a2d_i,
    input  logic [15:0] intgrl_i,
    input  logic [15:0] icomp_i,
    input  logic [15:0] pcomp_i,
    input  logic [15:0] pterm_i,
    input  src1sel_e    src1sel_i,
    input  src0sel_e    src0sel_i,
    input  logic        mult2_i,
    input  logic        mult4_i,
    input  logic        sub_i,
    input  logic        multiply_i,
    input  logic        saturate_i,
    output logic [15:0] dst_o
);

    logic [15:0]        src1_s;
    logic [15:0]        src0_s;
    logic [15:0]        scaled_s;
    logic [15:0]        sum_s;
    logic signed [31:0] prod_d;
    logic signed [31:0] prod_q;
    logic signed [31:0] prod_sh_s;

    always_comb begin
        case (src1sel_i)
            SRC1_ACCUM:  src1_s = accum_i;
            SRC1_ITERM:  src1_s = iterm_i;
            SRC1_ERROR:  src1_s = error_i;
            SRC1_ERRDIV: src1_s = errdiv_i;
            SRC1_FWD:    src1_s = fwd_i;
            default:     src1_s = 16'h0000;
        endcase
    end

    always_comb begin
        case (src0sel_i)
            SRC0_A2D:    src0_s = a2d_i;
            SRC0_INTGRL: src0_s = intgrl_i;
            SRC0_ICOMP:  src0_s = icomp_i;
            SRC0_PCOMP:  src0_s = pcomp_i;
            SRC0_PTERM:  src0_s = pterm_i;
            default:     src0_s = 16'h0000;
        endcase
    end

    always_comb begin
        if (mult2_i) begin
            scaled_s = {src0_s[14:0], 1'b0};
        end else if (mult4_i) begin
            scaled_s = {src0_s[13:0], 2'b00};
        end else begin
            scaled_s = src0_s;
        end
    end

    assign sum_s     = sub_i ? (src1_s - scaled_s) : (src1_s + scaled_s);
    assign prod_d    = $signed(src1_s) * $signed(src0_s);
    assign prod_sh_s = prod_q >>> 12;

    // Product pipeline register: the multiply result is valid one clock after its operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= 32'sd0;
        end else begin
            prod_q <= prod_d;
        end
    end

    always_comb begin
        if (multiply_i) begin
            dst_o = sat12(prod_sh_s);
        end else if (saturate_i) begin
            dst_o = sat12({{16{sum_s[15]}}, sum_s});
        end else begin
            dst_o = sum_s;
        end
    end

endmodule

// File: rtl/motion_cntrl.sv
// Line-follower control sequencer: scans three IR pairs through the A2D, builds a
// weighted position error, runs the PI loop through the alu, registers motor commands.
module motion_cntrl
    import motion_pkg::*;
#(
    parameter int SETTLE_CNT = 4096,
    parameter int INT_DEC    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        cnv_cmplt,
    input  logic [11:0] A2D_res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic        IR_in_en,
    output logic        IR_mid_en,
    output logic        IR_out_en,
    output logic [7:0]  LEDs,
    output logic [11:0] lft,
    output logic [11:0] rht,
    output logic        done
);

    localparam int TW = $clog2(SETTLE_CNT + 1);
    localparam int IW = $clog2(INT_DEC + 1);

    state_e          state_q;
    logic [1:0]      pair_q;
    logic [TW-1:0]   timer_q;
    logic [IW-1:0]   int_cnt_q;
    logic            mul_ph_q;
    logic [11:0]     a2d_q;
    logic [15:0]     accum_q;
    logic [11:0]     error_q;
    logic [11:0]     intgrl_q;
    logic [11:0]     icomp_q;
    logic [11:0]     pcomp_q;
    logic [11:0]     fwd_q;
    logic [11:0]     fwd_d;
    logic [12:0]     fwd_sum_s;
    logic            strt_cnv_q;
    logic [2:0]      chnnl_q;
    logic [2:0]      ir_en_q;
    logic [7:0]      leds_q;
    logic [11:0]     lft_q;
    logic [11:0]     rht_q;
    logic            done_q;

    src1sel_e        src1sel_s;
    src0sel_e        src0sel_s;
    logic            mult2_s;
    logic            mult4_s;
    logic            sub_s;
    logic            multiply_s;
    logic            saturate_s;
    logic [15:0]     alu_dst_s;

    assign fwd_sum_s = {1'b0, fwd_q} + {1'b0, FWD_STEP};

    always_comb begin
        if (fwd_sum_s > {1'b0, FWD_MAX}) begin
            fwd_d = FWD_MAX;
        end else begin
            fwd_d = fwd_sum_s[11:0];
        end
    end

    // alu operand selection and control, one operation per datapath state.
    always_comb begin
        src1sel_s  = SRC1_ACCUM;
        src0sel_s  = SRC0_A2D;
        mult2_s    = 1'b0;
        mult4_s    = 1'b0;
        sub_s      = 1'b0;
        multiply_s = 1'b0;
        saturate_s = 1'b0;
        case (state_q)
            ST_ACC_R, ST_ACC_L: begin
                mult2_s    = (pair_q == PAIR_MID);
                mult4_s    = (pair_q == PAIR_OUT);
                sub_s      = (state_q == ST_ACC_L);
                saturate_s = (state_q == ST_ACC_L) && (pair_q == PAIR_OUT);
            end
            ST_INTG: begin
                src1sel_s  = SRC1_ERRDIV;
                src0sel_s  = SRC0_INTGRL;
                saturate_s = 1'b1;
            end
            ST_ICMP: begin
                src1sel_s  = SRC1_ITERM;
                src0sel_s  = SRC0_INTGRL;
                multiply_s = 1'b1;
            end
            ST_PCMP: begin
                src1sel_s  = SRC1_ERROR;
                src0sel_s  = SRC0_PTERM;
                multiply_s = 1'b1;
            end
            ST_R1, ST_L1: begin
                src1sel_s  = SRC1_FWD;
                src0sel_s  = SRC0_PCOMP;
                sub_s      = (state_q == ST_R1);
            end
            ST_R2, ST_L2: begin
                src0sel_s  = SRC0_ICOMP;
                sub_s      = (state_q == ST_R2);
                saturate_s = 1'b1;
            end
            default: begin
                src1sel_s  = SRC1_ACCUM;
                src0sel_s  = SRC0_A2D;
            end
        endcase
    end

    motion_cntrl_alu u_alu (
        .clk        (clk),
        .rst_n      (rst_n),
        .accum_i    (accum_q),
        .iterm_i    ({4'h0, ITERM}),
        .error_i    ({{4{error_q[11]}}, error_q}),
        .errdiv_i   ({{8{error_q[11]}}, error_q[11:4]}),
        .fwd_i      ({4'h0, fwd_q}),
        .a2d_i      ({4'h0, a2d_q}),
        .intgrl_i   ({{4{intgrl_q[11]}}, intgrl_q}),
        .icomp_i    ({{4{icomp_q[11]}}, icomp_q}),
        .pcomp_i    ({{4{pcomp_q[11]}}, pcomp_q}),
        .pterm_i    ({2'b00, PTERM}),
        .src1sel_i  (src1sel_s),
        .src0sel_i  (src0sel_s),
        .mult2_i    (mult2_s),
        .mult4_i    (mult4_s),
        .sub_i      (sub_s),
        .multiply_i (multiply_s),
        .saturate_i (saturate_s),
        .dst_o      (alu_dst_s)
    );

    // Sequencer: state, operand registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pair_q     <= PAIR_IN;
            timer_q    <= '0;
            int_cnt_q  <= '0;
            mul_ph_q   <= 1'b0;
            a2d_q      <= 12'h000;
            accum_q    <= 16'h0000;
            error_q    <= 12'h000;
            intgrl_q   <= 12'h000;
            icomp_q    <= 12'h000;
            pcomp_q    <= 12'h000;
            fwd_q      <= 12'h000;
            strt_cnv_q <= 1'b0;
            chnnl_q    <= 3'd0;
            ir_en_q    <= 3'b000;
            leds_q     <= 8'h00;
            lft_q      <= 12'h000;
            rht_q      <= 12'h000;
            done_q     <= 1'b0;
        end else begin
            strt_cnv_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        fwd_q   <= fwd_d;
                        accum_q <= 16'h0000;
                        pair_q  <= PAIR_IN;
                        timer_q <= '0;
                        ir_en_q <= pair_enables(PAIR_IN);
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_q == TW'(SETTLE_CNT - 1)) begin
                        timer_q    <= '0;
                        strt_cnv_q <= 1'b1;
                        chnnl_q    <= chnl_right(pair_q);
                        state_q    <= ST_CONV_R;
                    end else begin
                        timer_q    <= timer_q + TW'(1);
                    end
                end
                ST_CONV_R: begin
                    if (cnv_cmplt) begin
                        a2d_q   <= A2D_res;
                        state_q <= ST_ACC_R;
                    end
                end
                ST_ACC_R: begin
                    accum_q    <= alu_dst_s;
                    strt_cnv_q <= 1'b1;
                    chnnl_q    <= chnl_left(pair_q);
                    state_q    <= ST_CONV_L;
                end
                ST_CONV_L: begin
                    if (cnv_cmplt) begin
                        a2d_q   <= A2D_res;
                        state_q <= ST_ACC_L;
                    end
                end
                ST_ACC_L: begin
                    if (pair_q == PAIR_OUT) begin
                        error_q <= alu_dst_s[11:0];
                        leds_q  <= alu_dst_s[11:4];
                        ir_en_q <= 3'b000;
                        state_q <= ST_INTG;
                    end else begin
                        accum_q <= alu_dst_s;
                        pair_q  <= pair_q + 2'd1;
                        ir_en_q <= pair_enables(pair_q + 2'd1);
                        timer_q <= '0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_INTG: begin
                    if (int_cnt_q == IW'(INT_DEC - 1)) begin
                        intgrl_q  <= alu_dst_s[11:0];
                        int_cnt_q <= '0;
                    end else begin
                        int_cnt_q <= int_cnt_q + IW'(1);
                    end
                    mul_ph_q <= 1'b0;
                    state_q  <= ST_ICMP;
                end
                ST_ICMP: begin
                    if (mul_ph_q) begin
                        icomp_q  <= alu_dst_s[11:0];
                        mul_ph_q <= 1'b0;
                        state_q  <= ST_PCMP;
                    end else begin
                        mul_ph_q <= 1'b1;
                    end
                end
                ST_PCMP: begin
                    if (mul_ph_q) begin
                        pcomp_q  <= alu_dst_s[11:0];
                        mul_ph_q <= 1'b0;
                        state_q  <= ST_R1;
                    end else begin
                        mul_ph_q <= 1'b1;
                    end
                end
                ST_R1: begin
                    accum_q <= alu_dst_s;
                    state_q <= ST_R2;
                end
                ST_R2: begin
                    rht_q   <= alu_dst_s[11:0];
                    state_q <= ST_L1;
                end
                ST_L1: begin
                    accum_q <= alu_dst_s;
                    state_q <= ST_L2;
                end
                ST_L2: begin
                    lft_q   <= alu_dst_s[11:0];
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ir_en_q <= 3'b000;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign strt_cnv  = strt_cnv_q;
    assign chnnl     = chnnl_q;
    assign IR_in_en  = ir_en_q[0];
    assign IR_mid_en = ir_en_q[1];
    assign IR_out_en = ir_en_q[2];
    assign LEDs      = leds_q;
    assign lft       = lft_q;
    assign rht       = rht_q;
    assign done      = done_q;

endmodule

// File: tb/tb_motion_cntrl.sv
// Scoreboard bench for motion_cntrl: an A2D model answers conversions, a reference
// model predicts lft/rht/LEDs per go, and monitors compare on done and strt_cnv.
module tb_motion_cntrl;

    localparam int SETTLE = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        IR_in_en;
    logic        IR_mid_en;
    logic        IR_out_en;
    logic [7:0]  LEDs;
    logic [11:0] lft;
    logic [11:0] rht;
    logic        done;

    always #5 clk = ~clk;

    motion_cntrl #(.SETTLE_CNT(SETTLE), .INT_DEC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .cnv_cmplt (cnv_cmplt),
        .A2D_res   (A2D_res),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .IR_in_en  (IR_in_en),
        .IR_mid_en (IR_mid_en),
        .IR_out_en (IR_out_en),
        .LEDs      (LEDs),
        .lft       (lft),
        .rht       (rht),
        .done      (done)
    );

    typedef struct {
        int lft;
        int rht;
        int leds;
    } e_t;

    int errors = 0;
    int checks = 0;
    int ch_val [8];
    int a2d_lat = 8;
    int done_cnt = 0;
    e_t sb_q [$];
    int chn_log [$];
    int order [6] = '{1, 0, 4, 2, 3, 7};
    int m_fwd = 0;
    int m_intgrl = 0;
    int m_iter = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int clamp12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Reference model for one iteration, from channel readings straight to commands.
    task automatic predict();
        int e, pc, ic;
        e_t x;
        e = (ch_val[1] - ch_val[0]) + 2 * (ch_val[4] - ch_val[2]) + 4 * (ch_val[3] - ch_val[7]);
        e = clamp12(e);
        m_fwd = (m_fwd + 16 > 895) ? 895 : m_fwd + 16;
        m_iter++;
        if (m_iter % 4 == 0) m_intgrl = clamp12(m_intgrl + (e >>> 4));
        ic = clamp12((1280 * m_intgrl) >>> 12);
        pc = clamp12((e * 13952) >>> 12);
        x.rht  = clamp12(m_fwd - pc - ic) & 32'hFFF;
        x.lft  = clamp12(m_fwd + pc + ic) & 32'hFFF;
        x.leds = (e & 32'hFFF) >> 4;
        sb_q.push_back(x);
    endtask

    // A2D model: answers each strt_cnv after a programmable number of clocks.
    initial begin
        int ch;
        cnv_cmplt = 1'b0;
        A2D_res   = 12'h000;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && strt_cnv === 1'b1) begin
                ch = int'(chnnl);
                chn_log.push_back(ch);
                if (a2d_lat > 0) repeat (a2d_lat) @(negedge clk);
                chk("chnnl_hold", int'(chnnl), ch);
                cnv_cmplt = 1'b1;
                A2D_res   = 12'(ch_val[ch]);
                @(negedge clk);
                cnv_cmplt = 1'b0;
                A2D_res   = 12'($urandom);
            end
        end
    end

    // Scoreboard monitor: pops the prediction whenever the DUT reports done.
    always @(negedge clk) begin
        e_t x;
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                x = sb_q.pop_front();
                chk("lft", int'(lft), x.lft);
                chk("rht", int'(rht), x.rht);
                chk("leds", int'(LEDs), x.leds);
            end
            chk("chnnl_count", chn_log.size(), 6);
            if (chn_log.size() == 6) begin
                for (int i = 0; i < 6; i++) chk("chnnl_order", chn_log[i], order[i]);
            end
            chn_log.delete();
        end
    end

    logic [2:0] en_prev = 3'b000;
    int         settle_cnt = 0;
    bit         armed = 1'b0;

    // Settle monitor: emitter-on clocks before each pair's first conversion.
    always @(negedge clk) begin
        logic [2:0] en;
        en = {IR_out_en, IR_mid_en, IR_in_en};
        if (en != en_prev && en != 3'b000) begin
            armed = 1'b1;
            settle_cnt = 0;
        end
        if (armed) begin
            if (strt_cnv === 1'b1) begin
                chk("settle_clks", settle_cnt, SETTLE);
                chk("ir_onehot", $countones(en), 1);
                armed = 1'b0;
            end else begin
                settle_cnt++;
            end
        end
        en_prev = en;
    end

    task automatic set_all(input int v);
        for (int i = 0; i < 8; i++) ch_val[i] = v;
    endtask

    task automatic set_rl(input int r, input int l);
        ch_val[1] = r; ch_val[4] = r; ch_val[3] = r;
        ch_val[0] = l; ch_val[2] = l; ch_val[7] = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        go    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_fwd = 0; m_intgrl = 0; m_iter = 0;
        sb_q.delete();
        chn_log.delete();
    endtask

    task automatic run_iter(input bit extra_go);
        int t0, waitc;
        predict();
        t0 = done_cnt;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        if (extra_go) begin
            repeat (20) @(negedge clk);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        waitc = 0;
        while (done_cnt == t0 && waitc < 3000) begin
            @(negedge clk);
            waitc++;
        end
        if (done_cnt == t0) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        set_all(32'h100);
        repeat (3) @(negedge clk);
        chk("rst_lft", int'(lft), 0);
        chk("rst_rht", int'(rht), 0);
        chk("rst_leds", int'(LEDs), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_strt", int'(strt_cnv), 0);
        chk("rst_en", int'({IR_out_en, IR_mid_en, IR_in_en}), 0);
        rst_n = 1'b1;

        // Balanced readings: zero error, commands equal Fwd.
        run_iter(1'b0);
        chk("bal_lft", int'(lft), 32'h010);
        chk("bal_rht", int'(rht), 32'h010);

        // Reset while the inner pair settles.
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        chk("ir_in_before_rst", int'(IR_in_en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_en", int'({IR_out_en, IR_mid_en, IR_in_en}), 0);
        chk("midrst_lft", int'(lft), 0);
        chk("midrst_rht", int'(rht), 0);
        rst_n = 1'b1;
        m_fwd = 0; m_intgrl = 0; m_iter = 0;
        sb_q.delete();
        chn_log.delete();

        // Inner right reads high: positive error, first iteration after reset.
        set_all(32'h100);
        ch_val[1] = 32'h200;
        run_iter(1'b0);
        chk("err100_leds", int'(LEDs), 32'h10);
        chk("lr_sum", int'((lft + rht) & 12'hFFF), 32'h020);
        chk("lft_gt_rht", int'($signed(lft) > $signed(rht)), 1);

        // Extreme readings saturate Error; second run also pulses go mid-scan.
        set_rl(32'hFFF, 32'h000);
        run_iter(1'b0);
        chk("sat_pos_leds", int'(LEDs), 32'h7F);
        set_rl(32'h000, 32'hFFF);
        run_iter(1'b1);
        chk("sat_neg_leds", int'(LEDs), 32'h80);

        // Fwd ramps to its ceiling with zero error.
        do_reset();
        set_all(32'h100);
        a2d_lat = 0;
        for (int i = 0; i < 60; i++) run_iter(1'b0);
        chk("fwd_clamp_lft", int'(lft), 32'h37F);
        chk("fwd_clamp_rht", int'(rht), 32'h37F);

        // Constant error: integral steps every fourth go.
        do_reset();
        a2d_lat = 3;
        set_all(32'h100);
        ch_val[1] = 32'h200;
        for (int i = 0; i < 12; i++) run_iter(1'b0);

        // Random readings and conversion latencies.
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 8; c++) ch_val[c] = int'($urandom_range(0, 4095));
            a2d_lat = int'($urandom_range(0, 8));
            run_iter(i % 7 == 3);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
